// File: rtl/minesweeper_input_ctrl_if.sv
// ---------------------------------------------------------------------------
// minesweeper_input_ctrl_if
// Command handshake between the input controller (master) and the game
// logic (slave).
//   cmd_valid : master -> slave, a command is pending
//   cmd_ready : slave  -> master, the command is accepted this cycle
//   cmd_op    : master -> slave, 0 = reveal, 1 = flag
//   cmd_row   : master -> slave, target row    (ROW_W bits)
//   cmd_col   : master -> slave, target column (COL_W bits)
// ---------------------------------------------------------------------------
interface minesweeper_input_ctrl_if #(
   parameter int ROW_W = 4,
   parameter int COL_W = 4
) ();
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_op;
   logic [ROW_W-1:0] cmd_row;
   logic [COL_W-1:0] cmd_col;

   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_row,
      output cmd_col,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_row,
      input  cmd_col,
      output cmd_ready
   );
endinterface

// File: rtl/minesweeper_input_ctrl.sv
// ---------------------------------------------------------------------------
// minesweeper_input_ctrl
// Turns debounced front-panel events into cursor moves and reveal/flag
// commands for the MineSweeper core. One event is acted on per cycle
// (center > up > down > left > right); held direction buttons auto-repeat
// when the macro INPUT_CTRL_AUTOREPEAT_EN is defined, otherwise moves come
// only from press pulses and btn_level_i is ignored.
//
// Ports
//   clk, rst       : clock, synchronous active-high reset
//   btn_level_i[5] : debounced levels  [0]up [1]down [2]left [3]right [4]center
//   btn_pulse_i[5] : one-cycle press pulses, same bit map
//   sw_i[8]        : [0] wrap enable, [1] flag mode, rest unused
//   cur_row_o/cur_col_o : cursor position
//   move_strobe_o  : one-cycle pulse with every real cursor change
//   cmd_drop_o     : one-cycle pulse when a center press was lost
//   cmd_if         : command handshake (master side)
// ---------------------------------------------------------------------------
module minesweeper_input_ctrl #(
   parameter int ROWS          = 16,
   parameter int COLS          = 16,
   parameter int HOLD_DELAY    = 25000000,
   parameter int REPEAT_PERIOD = 5000000,
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [4:0]                btn_level_i,
   input  logic [4:0]                btn_pulse_i,
   input  logic [7:0]                sw_i,
   output logic [ROW_W-1:0]          cur_row_o,
   output logic [COL_W-1:0]          cur_col_o,
   output logic                      move_strobe_o,
   output logic                      cmd_drop_o,
   minesweeper_input_ctrl_if.master  cmd_if
);

   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);
   localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);

   logic [ROW_W-1:0] cur_row_q, cur_row_d;
   logic [COL_W-1:0] cur_col_q, cur_col_d;
   logic             move_strobe_q, move_strobe_d;
   logic             cmd_valid_q, cmd_valid_d;
   logic             cmd_op_q, cmd_op_d;
   logic [ROW_W-1:0] cmd_row_q, cmd_row_d;
   logic [COL_W-1:0] cmd_col_q, cmd_col_d;
   logic             cmd_drop_q, cmd_drop_d;

   logic             center_s;
   logic             dir_pulse_s;
   logic [1:0]       dir_sel_s;
   logic             rep_s;
   logic [1:0]       rep_dir_s;
   logic             move_s;
   logic [1:0]       move_dir_s;
   logic             unused_s;

   // Priority arbitration: center blocks all directions, then up/down/left/right.
   always_comb begin
      center_s    = btn_pulse_i[4];
      dir_pulse_s = 1'b0;
      dir_sel_s   = 2'd0;
      if (btn_pulse_i[4]) begin
         dir_pulse_s = 1'b0;
      end else if (btn_pulse_i[0]) begin
         dir_pulse_s = 1'b1;
         dir_sel_s   = 2'd0;
      end else if (btn_pulse_i[1]) begin
         dir_pulse_s = 1'b1;
         dir_sel_s   = 2'd1;
      end else if (btn_pulse_i[2]) begin
         dir_pulse_s = 1'b1;
         dir_sel_s   = 2'd2;
      end else if (btn_pulse_i[3]) begin
         dir_pulse_s = 1'b1;
         dir_sel_s   = 2'd3;
      end else begin
         dir_pulse_s = 1'b0;
      end
   end

`ifdef INPUT_CTRL_AUTOREPEAT_EN
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } state_t;

   localparam logic [31:0] HOLD_LAST   = 32'(HOLD_DELAY - 1);
   localparam logic [31:0] REPEAT_LAST = 32'(REPEAT_PERIOD - 1);

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [1:0]  held_dir_q, held_dir_d;

   // Auto-repeat state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 32'd0;
         held_dir_q <= 2'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         held_dir_q <= held_dir_d;
      end
   end

   // Auto-repeat next state; an accepted direction pulse always restarts HOLD.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      held_dir_d = held_dir_q;
      rep_s      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = 32'd0;
         end
         ST_HOLD: begin
            if (btn_level_i[held_dir_q] == 1'b0) begin
               state_d = ST_IDLE;
               cnt_d   = 32'd0;
            end else if (cnt_q == HOLD_LAST) begin
               rep_s   = 1'b1;
               cnt_d   = 32'd0;
               state_d = ST_REPEAT;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         ST_REPEAT: begin
            if (btn_level_i[held_dir_q] == 1'b0) begin
               state_d = ST_IDLE;
               cnt_d   = 32'd0;
            end else if (cnt_q == REPEAT_LAST) begin
               rep_s = 1'b1;
               cnt_d = 32'd0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 32'd0;
         end
      endcase
      if (dir_pulse_s) begin
         held_dir_d = dir_sel_s;
         cnt_d      = 32'd0;
         state_d    = ST_HOLD;
      end else begin
         held_dir_d = held_dir_d;
      end
   end

   assign rep_dir_s = held_dir_q;
   assign unused_s  = ^{sw_i[7:2], btn_level_i[4]};
`else
   assign rep_s     = 1'b0;
   assign rep_dir_s = 2'd0;
   assign unused_s  = ^{sw_i[7:2], btn_level_i};
`endif

   // Move source: any accepted pulse (center included) suppresses a repeat.
   always_comb begin
      move_s     = 1'b0;
      move_dir_s = 2'd0;
      if (dir_pulse_s) begin
         move_s     = 1'b1;
         move_dir_s = dir_sel_s;
      end else if (rep_s && !center_s) begin
         move_s     = 1'b1;
         move_dir_s = rep_dir_s;
      end else begin
         move_s = 1'b0;
      end
   end

   // Cursor next position with wrap/clamp; strobe only on a real change.
   always_comb begin
      cur_row_d     = cur_row_q;
      cur_col_d     = cur_col_q;
      move_strobe_d = 1'b0;
      if (move_s) begin
         case (move_dir_s)
            2'd0: begin
               if (cur_row_q != '0) begin
                  cur_row_d = cur_row_q - ROW_ONE;  move_strobe_d = 1'b1;
               end else if (sw_i[0]) begin
                  cur_row_d = ROW_MAX;              move_strobe_d = 1'b1;
               end else begin
                  move_strobe_d = 1'b0;
               end
            end
            2'd1: begin
               if (cur_row_q != ROW_MAX) begin
                  cur_row_d = cur_row_q + ROW_ONE;  move_strobe_d = 1'b1;
               end else if (sw_i[0]) begin
                  cur_row_d = '0;                   move_strobe_d = 1'b1;
               end else begin
                  move_strobe_d = 1'b0;
               end
            end
            2'd2: begin
               if (cur_col_q != '0) begin
                  cur_col_d = cur_col_q - COL_ONE;  move_strobe_d = 1'b1;
               end else if (sw_i[0]) begin
                  cur_col_d = COL_MAX;              move_strobe_d = 1'b1;
               end else begin
                  move_strobe_d = 1'b0;
               end
            end
            default: begin
               if (cur_col_q != COL_MAX) begin
                  cur_col_d = cur_col_q + COL_ONE;  move_strobe_d = 1'b1;
               end else if (sw_i[0]) begin
                  cur_col_d = '0;                   move_strobe_d = 1'b1;
               end else begin
                  move_strobe_d = 1'b0;
               end
            end
         endcase
      end else begin
         move_strobe_d = 1'b0;
      end
   end

   // Command slot: load on center when empty; a center press while full is
   // dropped, even in the transfer cycle, so a new command never reloads early.
   always_comb begin
      cmd_valid_d = cmd_valid_q;
      cmd_op_d    = cmd_op_q;
      cmd_row_d   = cmd_row_q;
      cmd_col_d   = cmd_col_q;
      cmd_drop_d  = 1'b0;
      if (center_s && !cmd_valid_q) begin
         cmd_valid_d = 1'b1;
         cmd_op_d    = sw_i[1];
         cmd_row_d   = cur_row_q;
         cmd_col_d   = cur_col_q;
      end else if (center_s) begin
         cmd_drop_d = 1'b1;
         if (cmd_if.cmd_ready) begin
            cmd_valid_d = 1'b0;
         end else begin
            cmd_valid_d = 1'b1;
         end
      end else if (cmd_valid_q && cmd_if.cmd_ready) begin
         cmd_valid_d = 1'b0;
      end else begin
         cmd_valid_d = cmd_valid_q;
      end
   end

   // Output and command registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_row_q     <= '0;
         cur_col_q     <= '0;
         move_strobe_q <= 1'b0;
         cmd_valid_q   <= 1'b0;
         cmd_op_q      <= 1'b0;
         cmd_row_q     <= '0;
         cmd_col_q     <= '0;
         cmd_drop_q    <= 1'b0;
      end else begin
         cur_row_q     <= cur_row_d;
         cur_col_q     <= cur_col_d;
         move_strobe_q <= move_strobe_d;
         cmd_valid_q   <= cmd_valid_d;
         cmd_op_q      <= cmd_op_d;
         cmd_row_q     <= cmd_row_d;
         cmd_col_q     <= cmd_col_d;
         cmd_drop_q    <= cmd_drop_d;
      end
   end

   assign cur_row_o        = cur_row_q;
   assign cur_col_o        = cur_col_q;
   assign move_strobe_o    = move_strobe_q;
   assign cmd_drop_o       = cmd_drop_q;
   assign cmd_if.cmd_valid = cmd_valid_q;
   assign cmd_if.cmd_op    = cmd_op_q;
   assign cmd_if.cmd_row   = cmd_row_q;
   assign cmd_if.cmd_col   = cmd_col_q;

endmodule

// File: tb/tb_minesweeper_input_ctrl.sv
// Scoreboard bench: stimulus pushes expected moves / commands / drops into
// queues, a negedge monitor pops and compares whenever the DUT presents one.
module tb_minesweeper_input_ctrl;
   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int HD   = 8;
   localparam int RP   = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] btn_level;
   logic [4:0] btn_pulse;
   logic [7:0] sw;
   logic [1:0] cur_row;
   logic [1:0] cur_col;
   logic       move_strobe;
   logic       cmd_drop;

   minesweeper_input_ctrl_if #(.ROW_W(2), .COL_W(2)) cmd_if ();

   minesweeper_input_ctrl #(
      .ROWS(ROWS), .COLS(COLS), .HOLD_DELAY(HD), .REPEAT_PERIOD(RP)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .btn_level_i  (btn_level),
      .btn_pulse_i  (btn_pulse),
      .sw_i         (sw),
      .cur_row_o    (cur_row),
      .cur_col_o    (cur_col),
      .move_strobe_o(move_strobe),
      .cmd_drop_o   (cmd_drop),
      .cmd_if       (cmd_if)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int cyc; int row; int col; } mv_t;
   typedef struct { int op; int row; int col; } cmd_t;
   mv_t  mq[$];
   cmd_t cq[$];
   int   dq[$];

   int pass_cnt = 0;
   int chk_cnt  = 0;

   task automatic check(input string name, input int act, input int exp);
      chk_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic exp_move(input int c, input int r, input int col);
      mv_t e;
      e.cyc = c; e.row = r; e.col = col;
      mq.push_back(e);
   endtask

   task automatic exp_cmd(input int op, input int r, input int col);
      cmd_t e;
      e.op = op; e.row = r; e.col = col;
      cq.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [4:0] p);
      btn_pulse = p;
      step();
      btn_pulse = 5'd0;
   endtask

   function automatic int cmd_word();
      return int'(cmd_if.cmd_valid) * 32 + int'(cmd_if.cmd_op) * 16 +
             int'(cmd_if.cmd_row) * 4 + int'(cmd_if.cmd_col);
   endfunction

   // Monitor: compare every presented move / transfer / drop against the queues.
   mv_t  m_e;
   cmd_t m_c;
   int   m_d;
   logic prev_valid = 1'b0;
   int   prev_word  = 0;
   always @(negedge clk) begin
      if (!rst) begin
         if (move_strobe) begin
            if (mq.size() == 0) begin
               chk_cnt++;
               $display("FAIL unexpected_move: got (%0d,%0d), expected no move (cycle %0d)",
                        cur_row, cur_col, cyc);
            end else begin
               m_e = mq.pop_front();
               check("move_cycle", cyc, m_e.cyc);
               check("move_pos", int'(cur_row) * 16 + int'(cur_col), m_e.row * 16 + m_e.col);
            end
         end
         if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
            if (cq.size() == 0) begin
               chk_cnt++;
               $display("FAIL unexpected_cmd: got transfer, expected none (cycle %0d)", cyc);
            end else begin
               m_c = cq.pop_front();
               check("cmd_fields", int'(cmd_if.cmd_op) * 16 + int'(cmd_if.cmd_row) * 4 +
                     int'(cmd_if.cmd_col), m_c.op * 16 + m_c.row * 4 + m_c.col);
            end
         end
         if (cmd_drop) begin
            if (dq.size() == 0) begin
               chk_cnt++;
               $display("FAIL unexpected_drop: got drop, expected none (cycle %0d)", cyc);
            end else begin
               m_d = dq.pop_front();
               check("drop_cycle", cyc, m_d);
            end
         end
         if (prev_valid && cmd_if.cmd_valid) check("cmd_stable", cmd_word(), prev_word);
         prev_valid = cmd_if.cmd_valid;
         prev_word  = cmd_word();
      end else begin
         prev_valid = 1'b0;
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_row"},    int'(cur_row), 0);
      check({tag, "_col"},    int'(cur_col), 0);
      check({tag, "_strobe"}, int'(move_strobe), 0);
      check({tag, "_drop"},   int'(cmd_drop), 0);
      check({tag, "_cmd"},    cmd_word(), 0);
   endtask

   initial begin
      int p;
      int q;
      rst = 1'b1; btn_level = 5'd0; btn_pulse = 5'd0; sw = 8'd0;
      cmd_if.cmd_ready = 1'b0;
      repeat (3) step();
      @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      step();

      // Right from (0,0).
      p = cyc; exp_move(p + 1, 0, 1);
      press(5'b01000);
      repeat (3) step();

      // Up at row 0, clamp.
      press(5'b00001);
      @(negedge clk);
      check("clamp_strobe", int'(move_strobe), 0);
      check("clamp_row", int'(cur_row), 0);
      step();

      // Up at row 0, wrap.
      sw = 8'd1;
      p = cyc; exp_move(p + 1, 3, 1);
      press(5'b00001);
      repeat (2) step();

      // Center + up + right together: command only.
      exp_cmd(0, 3, 1);
      press(5'b11001);
      @(negedge clk);
      check("arb_center_valid", int'(cmd_if.cmd_valid), 1);
      step();
      // Down + right: down wins, row 3 wraps to 0.
      p = cyc; exp_move(p + 1, 0, 1);
      press(5'b01010);
      step();
      cmd_if.cmd_ready = 1'b1;
      step();
      cmd_if.cmd_ready = 1'b0;
      check("valid_after_xfer1", int'(cmd_if.cmd_valid), 0);
      step();

      // Cursor to (2,1), flag command held under back-pressure.
      p = cyc; exp_move(p + 1, 1, 1); press(5'b00010); step();
      p = cyc; exp_move(p + 1, 2, 1); press(5'b00010); step();
      sw = 8'd3;
      exp_cmd(1, 2, 1);
      press(5'b10000);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("cmd_hold", cmd_word(), 57);
         step();
      end
      p = cyc; dq.push_back(p + 1);
      press(5'b10000);
      @(negedge clk);
      check("cmd_after_drop", cmd_word(), 57);
      step();
      cmd_if.cmd_ready = 1'b1;
      step();
      cmd_if.cmd_ready = 1'b0;
      check("valid_after_xfer2", int'(cmd_if.cmd_valid), 0);
      step();

      // Column to 0, then hold right.
      p = cyc; exp_move(p + 1, 2, 0); press(5'b00100); repeat (2) step();
      p = cyc;
      exp_move(p + 1, 2, 1);
`ifdef INPUT_CTRL_AUTOREPEAT_EN
      exp_move(p + 9, 2, 2);
      exp_move(p + 13, 2, 3);
      exp_move(p + 17, 2, 0);
      exp_move(p + 21, 2, 1);
`endif
      btn_level = 5'b01000;
      press(5'b01000);
      repeat (20) step();
      btn_level = 5'd0;
      repeat (8) step();

      // Hold right into REPEAT, then switch to left.
      p = cyc;
      exp_move(p + 1, 2, 2);
`ifdef INPUT_CTRL_AUTOREPEAT_EN
      exp_move(p + 9, 2, 3);
`endif
      btn_level = 5'b01000;
      press(5'b01000);
      repeat (9) step();
      q = cyc;
`ifdef INPUT_CTRL_AUTOREPEAT_EN
      exp_move(q + 1, 2, 2);
      exp_move(q + 9, 2, 1);
`else
      exp_move(q + 1, 2, 1);
`endif
      btn_level = 5'b00100;
      press(5'b00100);
      repeat (8) step();
      btn_level = 5'd0;
      repeat (8) step();

      // Reset while a command is pending and right is repeating.
      sw = 8'd1;
      press(5'b10000);
      step();
      p = cyc;
      exp_move(p + 1, 2, 2);
`ifdef INPUT_CTRL_AUTOREPEAT_EN
      exp_move(p + 9, 2, 3);
`endif
      btn_level = 5'b01000;
      press(5'b01000);
      repeat (9) step();
      rst = 1'b1;
      repeat (2) step();
      @(negedge clk);
      check_reset_outputs("midrst");
      rst = 1'b0;
      repeat (12) step();
      btn_level = 5'd0;
      step();

      check("moves_pending", mq.size(), 0);
      check("cmds_pending", cq.size(), 0);
      check("drops_pending", dq.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
